// File: rtl/cla_operand_loader.sv
// -----------------------------------------------------------------------------
// cla_operand_loader
//
// Operand-entry front end for the 16-bit CLA datapath. Operands A and B share
// the 16 slide switches, so they are captured one after the other, each on a
// debounced press of BtnLoad. Registered A, B, Cin and a Valid flag feed the
// adder; the entry phase is driven to LEDs.
//
// Optional feature (macro OPERAND_SUB_EN):
//   Adds input SubSw. When SubSw = 1 at the B capture, B <= ~Sw and Cin <= 1,
//   so the adder computes A - Sw in two's complement. Without the macro the
//   SubSw port is absent and the block is plain addition entry.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a new button level is accepted
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   Clk      in   1   board clock, rising edge
//   Rs       in   1   asynchronous active-high reset
//   Sw       in  16   slide switches, operand value (quasi-static)
//   CinSw    in   1   slide switch, carry-in value (quasi-static)
//   SubSw    in   1   subtract select, only with OPERAND_SUB_EN
//   BtnLoad  in   1   raw push button, asynchronous and bouncy
//   A        out 16   registered operand A
//   B        out 16   registered operand B
//   Cin      out  1   registered carry-in
//   Valid    out  1   high while A, B and Cin form a complete operand set
//   Phase    out  2   00 = LOAD_A, 01 = LOAD_B, 10 = READY
// -----------------------------------------------------------------------------
module cla_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        Clk,
    input  logic        Rs,
    input  logic [15:0] Sw,
    input  logic        CinSw,
`ifdef OPERAND_SUB_EN
    input  logic        SubSw,
`endif
    input  logic        BtnLoad,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        Cin,
    output logic        Valid,
    output logic [1:0]  Phase
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        READY  = 2'b10
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop synchronizer, then debounce.
    // Sw/CinSw are deliberately not synchronized; they only matter on the
    // capture edge, long after the operator stopped moving them.
    // ------------------------------------------------------------------
    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_level;
    logic             btn_level_q;
    logic             press;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= BtnLoad;
            btn_sync <= btn_meta;
        end
    end

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, and is cleared at the terminal count, so it cannot wrap.
    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                btn_level <= ~btn_level;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // Single-cycle event on the accepted 0->1 edge only; release and hold
    // produce nothing.
    assign press = btn_level & ~btn_level_q;

    // ------------------------------------------------------------------
    // Entry FSM with its operand registers.
    // ------------------------------------------------------------------
    phase_t      state, state_nxt;
    logic [15:0] a_nxt, b_nxt;
    logic        cin_nxt, valid_nxt;

    always_ff @(posedge Clk or posedge Rs) begin
        if (Rs) begin
            state <= LOAD_A;
            A     <= '0;
            B     <= '0;
            Cin   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            state <= state_nxt;
            A     <= a_nxt;
            B     <= b_nxt;
            Cin   <= cin_nxt;
            Valid <= valid_nxt;
        end
    end

    // NOTE: every always_comb output is defaulted to its hold value first so
    // no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        b_nxt     = B;
        cin_nxt   = Cin;
        valid_nxt = Valid;
        case (state)
            LOAD_A: begin
                if (press) begin
                    a_nxt     = Sw;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
`ifdef OPERAND_SUB_EN
                    if (SubSw) begin
                        // Two's complement: A + ~Sw + 1 = A - Sw.
                        b_nxt   = ~Sw;
                        cin_nxt = 1'b1;
                    end else begin
                        b_nxt   = Sw;
                        cin_nxt = CinSw;
                    end
`else
                    b_nxt     = Sw;
                    cin_nxt   = CinSw;
`endif
                    valid_nxt = 1'b1;
                    state_nxt = READY;
                end
            end
            READY: begin
                // A press here starts a new entry and counts as A's capture.
                if (press) begin
                    a_nxt     = Sw;
                    valid_nxt = 1'b0;
                    state_nxt = LOAD_B;
                end
            end
            default: begin
                // Unreachable code 11: recover without waiting for a press.
                state_nxt = LOAD_A;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign Phase = state;

endmodule

// File: tb/tb_cla_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_cla_operand_loader
//
// Self-checking bench for cla_operand_loader with DEBOUNCE_CYCLES = 4.
// A behavioural model (phase as an integer, operands as plain variables,
// updated once per accepted press) predicts every output. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cla_operand_loader;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic        clk;
    logic        rs;
    logic [15:0] sw;
    logic        cin_sw;
    logic        btn;
`ifdef OPERAND_SUB_EN
    logic        sub_sw;
`endif
    logic [15:0] a_out, b_out;
    logic        cin_out, valid_out;
    logic [1:0]  phase_out;

    cla_operand_loader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .Clk     (clk),
        .Rs      (rs),
        .Sw      (sw),
        .CinSw   (cin_sw),
`ifdef OPERAND_SUB_EN
        .SubSw   (sub_sw),
`endif
        .BtnLoad (btn),
        .A       (a_out),
        .B       (b_out),
        .Cin     (cin_out),
        .Valid   (valid_out),
        .Phase   (phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: entry phase 0 = A next, 1 = B next, 2 = complete.
    logic [15:0] m_a, m_b;
    logic        m_cin, m_valid;
    int          m_phase;

    function automatic void model_reset();
        m_a = 16'h0; m_b = 16'h0; m_cin = 1'b0; m_valid = 1'b0; m_phase = 0;
    endfunction

    function automatic void model_press(input logic [15:0] v, input logic c, input logic s);
        if (m_phase == 1) begin
            m_b     = s ? (16'hFFFF - v) : v;
            m_cin   = s ? 1'b1 : c;
            m_valid = 1'b1;
            m_phase = 2;
        end else begin
            // From phase 0 or 2 the press captures A and begins a new set.
            m_a     = v;
            m_valid = 1'b0;
            m_phase = 1;
        end
    endfunction

    function automatic logic [35:0] model_vec();
        return {m_a, m_b, m_cin, m_valid, 2'(m_phase)};
    endfunction

    // Full press: stable switches, button held 'hold' cycles, then enough idle
    // for the release to debounce.
    task automatic do_press(input logic [15:0] v, input logic c, input logic s, input int hold);
        @(negedge clk);
        sw     = v;
        cin_sw = c;
`ifdef OPERAND_SUB_EN
        sub_sw = s;
`endif
        btn    = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (2 + DEB + 4) @(negedge clk);
`ifdef OPERAND_SUB_EN
        model_press(v, c, s);
`else
        model_press(v, c, 1'b0);
`endif
    endtask

    task automatic test_reset();
        rs = 1'b1; btn = 1'b0; sw = 16'hA5A5; cin_sw = 1'b1;
`ifdef OPERAND_SUB_EN
        sub_sw = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rs = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        sw  = 16'h7777;
        btn = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL glitch_ignored: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

    task automatic test_load_a_latency();
        @(negedge clk);
        sw     = 16'h1234;
        cin_sw = 1'b0;
        btn    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2 + DEB) begin
                n_checks++;
                if (a_out !== 16'h0000 || phase_out !== 2'b00) begin
                    n_fail++;
                    $display("FAIL load_a_too_early: A=%h Phase=%b expected A=0000 Phase=00",
                             a_out, phase_out);
                end
            end
            if (k == 2 + DEB + 1) begin
                n_checks++;
                if (a_out !== 16'h1234 || phase_out !== 2'b01) begin
                    n_fail++;
                    $display("FAIL load_a_latency: A=%h Phase=%b expected A=1234 Phase=01",
                             a_out, phase_out);
                end
            end
            // Switches move while the button is still held: no second capture.
            if (k == 10) sw = 16'h5555;
        end
        btn = 1'b0;
        repeat (2 + DEB + 4) @(negedge clk);
        model_press(16'h1234, 1'b0, 1'b0);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL load_a_single_capture: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

    task automatic test_load_b_and_static();
        do_press(16'hFFFF, 1'b1, 1'b0, 8);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL load_b: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
        @(negedge clk);
        sw = 16'h0000; cin_sw = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL switch_static: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

    task automatic test_ready_restart();
        do_press(16'h00AA, 1'b0, 1'b0, 8);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL ready_restart: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rs = 1'b1;
        #1;
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, 36'h0);
        end
        #1 rs = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid_debounce();
        // Make the state non-trivial first.
        do_press(16'h4321, 1'b0, 1'b0, 8);
        @(negedge clk);
        sw  = 16'hBEEF;
        btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rs = 1'b1;
        #2 rs = 1'b0;
        model_reset();
        // Button stays down: a fresh debounce from reset must produce an A capture.
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (2 + DEB + 4) @(negedge clk);
        model_press(16'hBEEF, 1'b0, 1'b0);
        n_checks++;
        if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_mid_debounce: got %h expected %h",
                     {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
        end
    endtask

`ifdef OPERAND_SUB_EN
    task automatic test_subtract();
        test_async_reset();
        do_press(16'h0010, 1'b0, 1'b0, 8);
        do_press(16'h0003, 1'b0, 1'b1, 8);
        n_checks++;
        if (b_out !== 16'hFFFC || cin_out !== 1'b1 || valid_out !== 1'b1 ||
            a_out !== 16'h0010) begin
            n_fail++;
            $display("FAIL subtract: A=%h B=%h Cin=%b Valid=%b expected A=0010 B=FFFC Cin=1 Valid=1",
                     a_out, b_out, cin_out, valid_out);
        end
        sw = 16'h0000; sub_sw = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            logic        c, s;
            int          hold;
            v    = 16'($urandom);
            c    = 1'($urandom);
            s    = 1'($urandom);
            hold = int'($urandom_range(DEB + 2, 15));
            if ($urandom_range(0, 1) == 1) begin
                // Short bounce that must not register.
                @(negedge clk);
                btn = 1'b1;
                repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
                btn = 1'b0;
                repeat (2 + DEB + 2) @(negedge clk);
            end
            do_press(v, c, s, hold);
            // Wiggle switches between presses; nothing may follow them.
            sw = 16'($urandom); cin_sw = 1'($urandom);
            repeat (3) @(negedge clk);
            n_checks++;
            if ({a_out, b_out, cin_out, valid_out, phase_out} !== model_vec()) begin
                n_fail++;
                $display("FAIL random_press_%0d: got %h expected %h", i,
                         {a_out, b_out, cin_out, valid_out, phase_out}, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_load_a_latency();
        test_load_b_and_static();
        test_ready_restart();
        test_async_reset();
        test_reset_mid_debounce();
`ifdef OPERAND_SUB_EN
        test_subtract();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
